// File: rtl/traffic_request_scheduler_if.sv
// ----------------------------------------------------------------------------
// traffic_request_scheduler_if
//
// Bundles the sensor inputs, the light-controller feedback and the request
// outputs of the traffic request scheduler.
//
//   sensor_in[3:0]  raw road sensors            [3]=A [2]=B [1]=C [0]=D
//   light_en[3:0]   light controller feedback   same mapping, one-hot when legal
//   switch_to_a..d  registered one-hot requests to the light controller
//   pending[3:0]    latched requests not yet served
//   timeout_err     one-cycle pulse when a request is abandoned
//
// master: the scheduler.  slave: the sensor / light-controller side.
// ----------------------------------------------------------------------------
interface traffic_request_scheduler_if;
  logic [3:0] sensor_in;
  logic [3:0] light_en;
  logic       switch_to_a;
  logic       switch_to_b;
  logic       switch_to_c;
  logic       switch_to_d;
  logic [3:0] pending;
  logic       timeout_err;

  modport master (
    input  sensor_in, light_en,
    output switch_to_a, switch_to_b, switch_to_c, switch_to_d,
    output pending, timeout_err
  );

  modport slave (
    output sensor_in, light_en,
    input  switch_to_a, switch_to_b, switch_to_c, switch_to_d,
    input  pending, timeout_err
  );
endinterface

// File: rtl/traffic_request_scheduler.sv
// ----------------------------------------------------------------------------
// traffic_request_scheduler
//
// Upstream request stage of the four-way traffic light controller.
// Synchronises and debounces the four road sensors, latches each debounced
// press as a pending request, and issues one-hot switch requests to the light
// controller in round-robin order. A request is held until light_en confirms
// the change, or abandoned after ACK_TIMEOUT cycles. A new request is only
// issued once light_en has been stable for MIN_GREEN cycles.
//
// Ports:
//   clk   clock
//   rst   asynchronous, active-low reset
//   bus   traffic_request_scheduler_if.master (sensors, feedback, requests)
//
// Parameters:
//   DEBOUNCE_CYCLES  stable cycles before the debounced sensor changes (>=1)
//   MIN_GREEN        cycles light_en must be unchanged before a request (>=1)
//   ACK_TIMEOUT      cycles a request is held waiting for acknowledge (>=1)
// ----------------------------------------------------------------------------
module traffic_request_scheduler #(
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int MIN_GREEN       = 8,
  parameter int ACK_TIMEOUT     = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  traffic_request_scheduler_if.master   bus
);

  localparam int DB_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int MG_W = $clog2(MIN_GREEN + 1);
  localparam int TO_W = $clog2(ACK_TIMEOUT + 1);

  localparam logic [DB_W-1:0] DB_LAST = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [MG_W-1:0] MG_MAX  = MG_W'(MIN_GREEN);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(ACK_TIMEOUT - 1);

  typedef enum logic {
    S_IDLE,
    S_REQ
  } state_e;

  // Road code in round-robin order; bit position in the 4-bit vectors is 3-code.
  typedef enum logic [1:0] {
    ROAD_A = 2'd0,
    ROAD_B = 2'd1,
    ROAD_C = 2'd2,
    ROAD_D = 2'd3
  } road_e;

  function automatic logic [3:0] road_onehot(input road_e r);
    return 4'b1000 >> r;
  endfunction

  // --------------------------------------------------------------------------
  // Two-flop synchroniser
  // --------------------------------------------------------------------------
  logic [3:0] sync1_q, sync2_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
    end else begin
      // NOTE: non-blocking assignments let sync2_q take the old sync1_q value,
      // giving two real flop stages instead of one collapsed wire.
      sync1_q <= bus.sensor_in;
      sync2_q <= sync1_q;
    end
  end

  // --------------------------------------------------------------------------
  // Debounce: per-bit counter runs while the synchronised value disagrees
  // with the debounced value and clears as soon as they agree.
  // --------------------------------------------------------------------------
  logic [3:0]      deb_q, deb_d, deb_prev_q;
  logic [DB_W-1:0] deb_cnt_q [4];
  logic [DB_W-1:0] deb_cnt_d [4];

  always_comb begin
    // NOTE: every output of this block gets a default before any branch,
    // so no path leaves a value unassigned and no latch is inferred.
    deb_d = deb_q;
    for (int i = 0; i < 4; i++) begin
      deb_cnt_d[i] = '0;
      if (sync2_q[i] != deb_q[i]) begin
        if (deb_cnt_q[i] == DB_LAST) deb_d[i] = sync2_q[i];
        else                         deb_cnt_d[i] = deb_cnt_q[i] + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      deb_q      <= '0;
      deb_prev_q <= '0;
      // NOTE: this counter array is tiny state, not a RAM, so it is reset
      // like any other register; a real memory would be left unreset.
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= '0;
    end else begin
      deb_q      <= deb_d;
      deb_prev_q <= deb_q;
      for (int i = 0; i < 4; i++) deb_cnt_q[i] <= deb_cnt_d[i];
    end
  end

  // --------------------------------------------------------------------------
  // Min-green counter: restarts whenever light_en moves, saturates at MIN_GREEN
  // --------------------------------------------------------------------------
  logic [3:0]      light_prev_q;
  logic [MG_W-1:0] mg_q, mg_d;
  logic            green_ok;

  always_comb begin
    if (bus.light_en != light_prev_q) mg_d = '0;
    else if (mg_q == MG_MAX)          mg_d = mg_q;
    else                              mg_d = mg_q + 1'b1;
  end

  assign green_ok = (mg_q == MG_MAX);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      light_prev_q <= '0;
      mg_q         <= '0;
    end else begin
      light_prev_q <= bus.light_en;
      mg_q         <= mg_d;
    end
  end

  // --------------------------------------------------------------------------
  // Request latch and round-robin selection
  // --------------------------------------------------------------------------
  state_e          state_q;
  road_e           sel_q, last_q, next_sel;
  logic [3:0]      switch_q;
  logic            timeout_q;
  logic [TO_W-1:0] tmr_q;
  logic [3:0]      pending_q, pending_d;
  logic [3:0]      set_mask, clr_mask;
  logic            ack;
  logic            found;
  logic [1:0]      cand;

  // A press on a road that is already green is not worth a request.
  assign set_mask = deb_q & ~deb_prev_q & ~bus.light_en;

  // Exact compare: a non-one-hot light_en can never match.
  assign ack      = (bus.light_en == road_onehot(sel_q));
  assign clr_mask = (state_q == S_REQ && ack) ? road_onehot(sel_q) : 4'b0000;

  // Sets and clears are per bit, so they never interfere across roads.
  assign pending_d = (pending_q | set_mask) & ~clr_mask;

  // First pending road strictly after last_q, wrapping A->B->C->D->A.
  always_comb begin
    next_sel = last_q;
    found    = 1'b0;
    cand     = 2'd0;
    for (int k = 1; k <= 4; k++) begin
      cand = last_q + 2'(k);
      if (!found && (pending_q & road_onehot(road_e'(cand))) != 4'b0000) begin
        next_sel = road_e'(cand);
        found    = 1'b1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Request FSM with registered outputs
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      sel_q     <= ROAD_A;
      last_q    <= ROAD_A;
      switch_q  <= '0;
      timeout_q <= 1'b0;
      tmr_q     <= '0;
      pending_q <= '0;
    end else begin
      pending_q <= pending_d;
      timeout_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (pending_q != 4'b0000 && green_ok) begin
            state_q  <= S_REQ;
            sel_q    <= next_sel;
            switch_q <= road_onehot(next_sel);
            tmr_q    <= '0;
          end
        end
        S_REQ: begin
          if (ack) begin
            state_q  <= S_IDLE;
            switch_q <= '0;
            last_q   <= sel_q;
          end else if (tmr_q == TO_LAST) begin
            // Abandon the request but leave it pending; rotating last_q
            // lets the other roads go first next time.
            state_q   <= S_IDLE;
            switch_q  <= '0;
            timeout_q <= 1'b1;
            last_q    <= sel_q;
          end else begin
            tmr_q <= tmr_q + 1'b1;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign bus.switch_to_a = switch_q[3];
  assign bus.switch_to_b = switch_q[2];
  assign bus.switch_to_c = switch_q[1];
  assign bus.switch_to_d = switch_q[0];
  assign bus.pending     = pending_q;
  assign bus.timeout_err = timeout_q;

endmodule

// File: tb/tb_traffic_request_scheduler.sv
// ----------------------------------------------------------------------------
// tb_traffic_request_scheduler
//
// Directed bench for traffic_request_scheduler with default parameters.
// Expected grants are queued when the stimulus is applied; a monitor pops and
// compares them each time a new switch request appears.
// ----------------------------------------------------------------------------
module tb_traffic_request_scheduler;

  localparam int DEBOUNCE_CYCLES = 4;
  localparam int MIN_GREEN       = 8;
  localparam int ACK_TIMEOUT     = 16;

  logic clk;
  logic rst;

  int checks   = 0;
  int failures = 0;

  logic [3:0] grant_q [$];
  logic [3:0] sw;
  logic [3:0] sw_prev;

  traffic_request_scheduler_if bus ();

  traffic_request_scheduler #(
    .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
    .MIN_GREEN       (MIN_GREEN),
    .ACK_TIMEOUT     (ACK_TIMEOUT)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  assign sw = {bus.switch_to_a, bus.switch_to_b, bus.switch_to_c, bus.switch_to_d};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Scoreboard: every new non-zero switch vector must match the next queued grant.
  initial begin
    sw_prev = 4'b0000;
    forever begin
      @(negedge clk);
      if (sw != 4'b0000 && sw != sw_prev) begin
        if (grant_q.size() == 0) check("unexpected_grant", {4'b0, sw}, 8'h00);
        else                     check("grant_order", {4'b0, sw}, {4'b0, grant_q.pop_front()});
      end
      sw_prev = sw;
    end
  end

  task automatic do_reset(input logic [3:0] light);
    bus.sensor_in = 4'b0000;
    bus.light_en  = light;
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_switch",  {4'b0, sw}, 8'h00);
    check("rst_pending", {4'b0, bus.pending}, 8'h00);
    check("rst_timeout", {7'b0, bus.timeout_err}, 8'h00);
    rst = 1'b1;
    @(negedge clk);
  endtask

  // Waits (bounded) for any switch request, then checks it is the expected one.
  task automatic wait_switch(input int max_cycles, input logic [3:0] exp, output int n);
    n = 0;
    while (sw == 4'b0000 && n < max_cycles) begin
      @(negedge clk);
      n++;
    end
    check("switch_rise", {4'b0, sw}, {4'b0, exp});
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog simulation did not complete");
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures + 1);
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    int n;
    int hi;
    logic [3:0] pend_exp;
    logic [3:0] order [4];

    rst = 1'b1;
    bus.sensor_in = 4'b0000;
    bus.light_en  = 4'b0000;

    // ---- 1: single press of B, acknowledged --------------------------------
    do_reset(4'b1000);
    grant_q.push_back(4'b0100);
    bus.sensor_in = 4'b0100;
    // 2 sync + DEBOUNCE_CYCLES debounce + 1 edge-detect = edge 7.
    repeat (6) @(negedge clk);
    check("t1_pend_edge6", {4'b0, bus.pending}, 8'h00);
    @(negedge clk);
    check("t1_pend_edge7", {4'b0, bus.pending}, 8'h04);
    wait_switch(20, 4'b0100, n);
    repeat (2) @(negedge clk);
    bus.sensor_in = 4'b0000;
    check("t1_switch_held", {4'b0, sw}, 8'h04);
    bus.light_en = 4'b0100;
    @(negedge clk);
    check("t1_ack_switch",  {4'b0, sw}, 8'h00);
    check("t1_ack_pending", {4'b0, bus.pending}, 8'h00);

    // ---- 2: all four pending, round-robin from A -> B, C, D, A -------------
    do_reset(4'b0000);
    order[0] = 4'b0100; order[1] = 4'b0010; order[2] = 4'b0001; order[3] = 4'b1000;
    for (int i = 0; i < 4; i++) grant_q.push_back(order[i]);
    bus.sensor_in = 4'b1111;
    repeat (7) @(negedge clk);
    check("t2_pend_all", {4'b0, bus.pending}, 8'h0F);
    pend_exp = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      wait_switch(40, order[i], n);
      bus.sensor_in = 4'b0000;
      // After an acknowledge the counter restarts: MIN_GREEN increments,
      // then one more edge to issue.
      if (i > 0) check("t2_gap", 8'(n), 8'(MIN_GREEN + 1));
      bus.light_en = order[i];
      @(negedge clk);
      pend_exp = pend_exp & ~order[i];
      check("t2_ack_switch",  {4'b0, sw}, 8'h00);
      check("t2_ack_pending", {4'b0, bus.pending}, {4'b0, pend_exp});
    end

    // ---- 3: short glitch on C is filtered ----------------------------------
    do_reset(4'b1000);
    bus.sensor_in = 4'b0010;
    repeat (3) @(negedge clk);
    bus.sensor_in = 4'b0000;
    repeat (20) @(negedge clk);
    check("t3_glitch_pending", {4'b0, bus.pending}, 8'h00);
    check("t3_glitch_switch",  {4'b0, sw}, 8'h00);

    // ---- 4: D never acknowledged -> timeout, then search resumes at A ------
    do_reset(4'b0100);
    grant_q.push_back(4'b0001);
    grant_q.push_back(4'b1000);
    bus.sensor_in = 4'b1001;
    wait_switch(40, 4'b0001, n);
    bus.sensor_in = 4'b0000;
    hi = 1;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (sw == 4'b0001) hi++;
      else break;
    end
    check("t4_high_cycles", 8'(hi), 8'(ACK_TIMEOUT));
    check("t4_timeout_pulse", {7'b0, bus.timeout_err}, 8'h01);
    check("t4_pending_kept", {4'b0, bus.pending}, 8'h09);
    @(negedge clk);
    check("t4_timeout_end", {7'b0, bus.timeout_err}, 8'h00);
    wait_switch(5, 4'b1000, n);

    // ---- 5: press on a green road is ignored, elsewhere it latches ---------
    do_reset(4'b1000);
    bus.sensor_in = 4'b1000;
    repeat (8) @(negedge clk);
    bus.sensor_in = 4'b0000;
    repeat (8) @(negedge clk);
    check("t5_green_pending", {4'b0, bus.pending}, 8'h00);
    check("t5_green_switch",  {4'b0, sw}, 8'h00);
    grant_q.push_back(4'b1000);
    bus.light_en  = 4'b0010;
    bus.sensor_in = 4'b1000;
    repeat (7) @(negedge clk);
    check("t5_red_pending", {4'b0, bus.pending}, 8'h08);
    wait_switch(40, 4'b1000, n);
    bus.sensor_in = 4'b0000;

    // ---- 6: reset in the middle of a C request -----------------------------
    do_reset(4'b1000);
    grant_q.push_back(4'b0010);
    bus.sensor_in = 4'b0010;
    wait_switch(40, 4'b0010, n);
    bus.sensor_in = 4'b0000;
    repeat (3) @(negedge clk);
    check("t6_pre_switch",  {4'b0, sw}, 8'h02);
    check("t6_pre_pending", {4'b0, bus.pending}, 8'h02);
    #2 rst = 1'b0;
    #1;
    check("t6_async_switch",  {4'b0, sw}, 8'h00);
    check("t6_async_pending", {4'b0, bus.pending}, 8'h00);
    check("t6_async_timeout", {7'b0, bus.timeout_err}, 8'h00);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (12) @(negedge clk);
    check("t6_post_switch",  {4'b0, sw}, 8'h00);
    check("t6_post_pending", {4'b0, bus.pending}, 8'h00);

    check("grant_queue_empty", 8'(grant_q.size()), 8'h00);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/traffic_request_scheduler.md
# traffic_request_scheduler

Upstream request stage for the four-way traffic light controller. It synchronises and debounces the four raw road sensors (A–D) and latches each debounced press as a pending request. It then issues one-hot `switch_to_*` requests to the light controller in round-robin order, holding each until the controller's `light_en` feedback confirms the change. It enforces a minimum green time between changes and a timeout when a request is never acknowledged.

## Interface
- `DEBOUNCE_CYCLES`, default 4: consecutive stable cycles (≥1) before the debounced sensor value changes.
- `MIN_GREEN`, default 8: minimum cycles (≥1) `light_en` must stay unchanged before a new request is issued.
- `ACK_TIMEOUT`, default 16: maximum cycles (≥1) a request is held in REQ waiting for acknowledge.

Ports:
- `clk`  in  1  clock.
- `rst`  in  1  reset; asynchronous, active-low.
- `sensor_in`  in  4  raw, asynchronous, possibly bouncing road sensors; [3]=A, [2]=B, [1]=C, [0]=D.
- `light_en`  in  4  feedback from the light controller, same bit mapping; one-hot when legal.
- `switch_to_a`, `switch_to_b`, `switch_to_c`, `switch_to_d`  out  1 each  registered request lines; at most one high at a time.
- `pending`  out  4  latched requests not yet served, same bit mapping.
- `timeout_err`  out  1  one-cycle pulse when a request is abandoned.

## Operation
- **Synchroniser:** two-flop synchroniser per sensor bit.
- **Debounce:** per-bit counter; it counts while the synchronised value differs from the debounced value and clears when they match.
  - The debounced bit takes the new value on the edge where the count reaches `DEBOUNCE_CYCLES-1` while the values still differ.
  - Counter width is $clog2(DEBOUNCE_CYCLES+1).
- **Request latch:** a rising edge of debounced[i] sets pending[i].
  - Exception: the set is suppressed if light_en[i] is already high, because the road is already green.
  - pending[i] clears only on acknowledge of road i.
  - A set and a clear on different bits in the same cycle are independent.
- **Min-green counter:** saturates at `MIN_GREEN`.
  - It clears on any edge where `light_en` differs from its registered previous value, and increments otherwise.
  - `green_ok` = (count == `MIN_GREEN`).
- **Round-robin pointer `last`:** 2-bit, reset = A.
  - Search order starts at the road after `last`: A→B→C→D→A.
- **FSM states:** IDLE and REQ.
  - **IDLE → REQ:** when `pending` ≠ 0 and `green_ok`. On this edge, latch `sel` = first pending road in round-robin order and assert `switch_to_sel`.
  - **REQ, acknowledge:** `light_en` == onehot(`sel`). On that edge: deassert the switch, clear pending[sel], set `last` = `sel`, go to IDLE.
  - **REQ, timeout:** `ACK_TIMEOUT` cycles in REQ with no acknowledge. On that edge: deassert the switch, pulse `timeout_err` (high for exactly the next cycle), set `last` = `sel`, keep pending[sel], go to IDLE.
- A non-one-hot `light_en` is never treated as an acknowledge. It still resets the min-green counter when it changes.
- `sensor_in` activity during REQ only updates `pending`; `sel` does not change until return to IDLE.

## Timing
- Reset values:
  - FSM = IDLE.
  - All `switch_to_*` = 0, `pending` = 0, `timeout_err` = 0.
  - Debounced bits = 0, sync flops = 0, `last` = A, min-green count = 0.
  - Assertion of `rst` forces all outputs low immediately, including mid-REQ.
- Latency with a clean step on sensor_in[i] sampled at edge 0:
  - synchronised value high after edge 2;
  - debounced high after edge 1+`DEBOUNCE_CYCLES`+1;
  - pending[i] high after edge `DEBOUNCE_CYCLES`+3 (edge 7 with defaults).
- IDLE → REQ: `switch_to_*` rises on the edge after `pending` and `green_ok` are both true. Minimum 1 cycle from pending to switch.
- The switch stays high through REQ and drops on the acknowledge edge. The light controller samples requests only at its own phase boundary, so holding the request is mandatory.
- After acknowledge, the next request cannot issue for `MIN_GREEN` cycles, because `light_en` just changed.
- A sensor glitch shorter than `DEBOUNCE_CYCLES` synchronised cycles never sets `pending`.

## Test plan
- Reset, `light_en`=1000, press B (sensor_in=0100, held 10 cycles) → pending=0100 after edge 7. Once `green_ok`, `switch_to_b`=1; drive `light_en`=0100 → switch drops and pending=0000 on the same edge.
- Pending=1111 with `last`=A and the controller acknowledging each request → grant order B, C, D, then A (A is dropped if still green). Each issue is spaced ≥ `MIN_GREEN` cycles after the previous `light_en` change.
- 3-cycle pulse on sensor_in[1] (C) → pending stays 0000, no switch activity.
- Request D, never acknowledge → `switch_to_d` high for exactly 16 cycles, then `timeout_err` pulses for 1 cycle, pending[0] stays 1, `last`=D, and the next issue searches from A.
- Press A while `light_en`=1000 → pending[3] stays 0. Press A while C is green → pending[3]=1.
- Assert `rst` low mid-REQ with `switch_to_c`=1 → all outputs 0 immediately. After release, FSM is IDLE and pending=0000.
